// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86-64 constants, state encoding and widths for decode/writeback
package y86_pkg;
  localparam int DATA_W = 64;
  localparam int NREG = 15;
  localparam logic [3:0] I_HALT = 4'h0, I_NOP = 4'h1, I_RRMOVQ = 4'h2, I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4, I_MRMOVQ = 4'h5, I_OPQ = 4'h6, I_JXX = 4'h7;
  localparam logic [3:0] I_CALL = 4'h8, I_RET = 4'h9, I_PUSHQ = 4'hA, I_POPQ = 4'hB;
  localparam logic [3:0] RSP = 4'h4, RNONE = 4'hF;
  typedef enum logic [1:0] {S_IDLE, S_DEC_ACK, S_WAIT_WB, S_WB_ACK} state_t;
endpackage

// File: rtl/decode_writeback_if.sv
// decode_writeback_if: fetch/execute/memory handshake bundle around the register file
interface decode_writeback_if;
  import y86_pkg::*;
  logic dec_req, dec_ack, wb_req, wb_ack, cnd;
  logic [3:0] icode, ifun, rA, rB, ifun_e;
  logic [DATA_W-1:0] valA, valB, valE, valM;
  modport master (
    output dec_req, icode, ifun, rA, rB, wb_req, valE, valM, cnd,
    input dec_ack, valA, valB, wb_ack, ifun_e
  );
  modport slave (
    input dec_req, icode, ifun, rA, rB, wb_req, valE, valM, cnd,
    output dec_ack, valA, valB, wb_ack, ifun_e
  );
endinterface

// File: rtl/y86_regfile.sv
// y86_regfile: 15x64 register file, two read ports plus debug read, two write ports (M wins)
module y86_regfile
  import y86_pkg::*;
#(
  parameter logic [DATA_W-1:0] RSP_INIT = 64'h200
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        ra_addr,
  input  logic [3:0]        rb_addr,
  input  logic [3:0]        dbg_addr,
  output logic [DATA_W-1:0] ra_data,
  output logic [DATA_W-1:0] rb_data,
  output logic [DATA_W-1:0] dbg_data,
  input  logic [3:0]        we_addr,
  input  logic [DATA_W-1:0] we_data,
  input  logic [3:0]        wm_addr,
  input  logic [DATA_W-1:0] wm_data
);
  logic [DATA_W-1:0] regs [NREG];
  assign ra_data  = ra_addr == RNONE ? '0 : regs[ra_addr];
  assign rb_data  = rb_addr == RNONE ? '0 : regs[rb_addr];
  assign dbg_data = dbg_addr == RNONE ? '0 : regs[dbg_addr];
  // port M is written last so it overrides port E on the same index
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= (i == int'(RSP)) ? RSP_INIT : '0;
    end else begin
      if (we_addr != RNONE) regs[we_addr] <= we_data;
      if (wm_addr != RNONE) regs[wm_addr] <= wm_data;
    end
  end
endmodule

// File: rtl/decode_writeback.sv
// decode_writeback: Y86-64 decode/writeback register-file stage with ordered strobe/ack handshake
module decode_writeback
  import y86_pkg::*;
#(
  parameter logic [DATA_W-1:0] RSP_INIT = 64'h200
) (
  input  logic                clk,
  input  logic                rst,
  decode_writeback_if.slave   bus,
  output logic                halted,
  output logic                proto_err,
  input  logic [3:0]          dbg_addr,
  output logic [DATA_W-1:0]   dbg_data
);
  state_t state;
  logic [3:0] icode_q, ra_q, rb_q, src_a, src_b, dst_e, dst_m;
  logic [DATA_W-1:0] rd_a, rd_b;
  logic wr;
  assign wr = (state == S_WAIT_WB) && bus.wb_req;
  always_comb begin
    src_a = (bus.icode inside {I_RRMOVQ, I_RMMOVQ, I_OPQ, I_PUSHQ}) ? bus.rA :
            (bus.icode inside {I_RET, I_POPQ}) ? RSP : RNONE;
    src_b = (bus.icode inside {I_RMMOVQ, I_MRMOVQ, I_OPQ}) ? bus.rB :
            (bus.icode inside {I_CALL, I_RET, I_PUSHQ, I_POPQ}) ? RSP : RNONE;
    dst_e = !wr ? RNONE :
            (icode_q == I_RRMOVQ) ? (bus.cnd ? rb_q : RNONE) :
            (icode_q inside {I_IRMOVQ, I_OPQ}) ? rb_q :
            (icode_q inside {I_CALL, I_RET, I_PUSHQ, I_POPQ}) ? RSP : RNONE;
    dst_m = (wr && (icode_q inside {I_MRMOVQ, I_POPQ})) ? ra_q : RNONE;
  end
  y86_regfile #(.RSP_INIT(RSP_INIT)) u_rf (
    .clk(clk), .rst(rst),
    .ra_addr(src_a), .rb_addr(src_b), .dbg_addr(dbg_addr),
    .ra_data(rd_a), .rb_data(rd_b), .dbg_data(dbg_data),
    .we_addr(dst_e), .we_data(bus.valE),
    .wm_addr(dst_m), .wm_data(bus.valM)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      icode_q <= I_NOP;
      ra_q <= RNONE;
      rb_q <= RNONE;
      bus.ifun_e <= '0;
      bus.valA <= '0;
      bus.valB <= '0;
      bus.dec_ack <= 1'b0;
      bus.wb_ack <= 1'b0;
      halted <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      bus.dec_ack <= 1'b0;
      bus.wb_ack <= 1'b0;
      if (bus.dec_req && state != S_IDLE) proto_err <= 1'b1;
      case (state)
        S_IDLE: begin
          if (bus.wb_req) proto_err <= 1'b1;
          if (bus.dec_req && !halted) begin
            icode_q <= bus.icode;
            ra_q <= bus.rA;
            rb_q <= bus.rB;
            bus.ifun_e <= bus.ifun;
            bus.valA <= rd_a;
            bus.valB <= rd_b;
            bus.dec_ack <= 1'b1;
            state <= S_DEC_ACK;
            if (bus.icode > I_POPQ) proto_err <= 1'b1;
          end
        end
        S_DEC_ACK: state <= S_WAIT_WB;
        S_WAIT_WB: begin
          if (bus.wb_req) begin
            bus.wb_ack <= 1'b1;
            state <= S_WB_ACK;
            if (icode_q == I_HALT) halted <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_decode_writeback.sv
// tb_decode_writeback: directed vectors against a transaction-level register-file model
module tb_decode_writeback;
  import y86_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic halted, proto_err;
  logic [3:0] dbg_addr = 4'h0;
  logic [63:0] dbg_data;
  decode_writeback_if bus();
  decode_writeback dut (
    .clk(clk), .rst(rst), .bus(bus), .halted(halted), .proto_err(proto_err),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );
  always #5 clk = ~clk;
  logic [63:0] mregs [16];
  logic [63:0] exp_valA, exp_valB;
  logic [3:0] exp_ifun;
  logic exp_dec_ack, exp_wb_ack, exp_halted, exp_perr;
  logic chk_on = 1'b0;
  int errors = 0;
  int checks = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    foreach (mregs[i]) mregs[i] = 64'h0;
    mregs[4] = 64'h200;
    exp_valA = 0;
    exp_valB = 0;
    exp_ifun = 0;
    exp_dec_ack = 0;
    exp_wb_ack = 0;
    exp_halted = 0;
    exp_perr = 0;
  endtask
  function automatic logic [3:0] m_src_a(input logic [3:0] ic, input logic [3:0] ra);
    case (ic)
      4'h2, 4'h4, 4'h6, 4'hA: return ra;
      4'h9, 4'hB: return 4'h4;
      default: return 4'hF;
    endcase
  endfunction
  function automatic logic [3:0] m_src_b(input logic [3:0] ic, input logic [3:0] rb);
    case (ic)
      4'h4, 4'h5, 4'h6: return rb;
      4'h8, 4'h9, 4'hA, 4'hB: return 4'h4;
      default: return 4'hF;
    endcase
  endfunction
  function automatic logic [63:0] m_rd(input logic [3:0] idx);
    return idx == 4'hF ? 64'h0 : mregs[idx];
  endfunction
  task automatic m_wb(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                      input logic [63:0] ve, input logic [63:0] vm, input logic c);
    logic [3:0] de, dm;
    de = 4'hF;
    dm = 4'hF;
    case (ic)
      4'h2: if (c) de = rb;
      4'h3, 4'h6: de = rb;
      4'h8, 4'h9, 4'hA, 4'hB: de = 4'h4;
      default: de = 4'hF;
    endcase
    if (ic == 4'h5 || ic == 4'hB) dm = ra;
    if (de != 4'hF) mregs[de] = ve;
    if (dm != 4'hF) mregs[dm] = vm;
    if (ic == 4'h0) exp_halted = 1;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    dbg_addr = dbg_addr + 4'd1;
  endtask
  task automatic peek(input string name, input logic [3:0] a, input logic [63:0] exp);
    dbg_addr = a;
    #1;
    chk(name, dbg_data, exp);
  endtask
  task automatic do_reset();
    rst = 1;
    step();
    rst = 0;
    model_reset();
  endtask
  // one full decode/writeback transaction; poke fires a stray dec_req while waiting for writeback
  task automatic instr(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] ra,
                       input logic [3:0] rb, input logic [63:0] ve, input logic [63:0] vm,
                       input logic c, input bit poke);
    bus.dec_req = 1; bus.icode = ic; bus.ifun = fn; bus.rA = ra; bus.rB = rb;
    step();
    bus.dec_req = 0;
    exp_dec_ack = 1;
    exp_valA = m_rd(m_src_a(ic, ra));
    exp_valB = m_rd(m_src_b(ic, rb));
    exp_ifun = fn;
    if (ic > 4'hB) exp_perr = 1;
    step();
    exp_dec_ack = 0;
    if (poke) begin
      bus.dec_req = 1; bus.icode = 4'h3; bus.rB = 4'h1;
      step();
      bus.dec_req = 0;
      exp_perr = 1;
    end
    bus.wb_req = 1; bus.valE = ve; bus.valM = vm; bus.cnd = c;
    step();
    bus.wb_req = 0;
    exp_wb_ack = 1;
    m_wb(ic, ra, rb, ve, vm, c);
    step();
    exp_wb_ack = 0;
  endtask
  always @(negedge clk) begin
    if (chk_on) begin
      chk("dec_ack", 64'(bus.dec_ack), 64'(exp_dec_ack));
      chk("wb_ack", 64'(bus.wb_ack), 64'(exp_wb_ack));
      chk("halted", 64'(halted), 64'(exp_halted));
      chk("proto_err", 64'(proto_err), 64'(exp_perr));
      chk("valA", bus.valA, exp_valA);
      chk("valB", bus.valB, exp_valB);
      chk("ifun_e", 64'(bus.ifun_e), 64'(exp_ifun));
      chk("dbg_data", dbg_data, m_rd(dbg_addr));
    end
  end
  initial begin
    bus.dec_req = 0; bus.wb_req = 0; bus.icode = 0; bus.ifun = 0;
    bus.rA = 4'hF; bus.rB = 4'hF; bus.valE = 0; bus.valM = 0; bus.cnd = 0;
    step();
    step();
    rst = 0;
    model_reset();
    chk_on = 1;
    peek("rst_rsp", 4'h4, 64'h200);
    peek("rst_r0", 4'h0, 64'h0);
    peek("rst_rnone", 4'hF, 64'h0);
    instr(4'h3, 4'h0, 4'hF, 4'h2, 64'h55, 64'h0, 1'b0, 1'b0);
    peek("irmovq_r2", 4'h2, 64'h55);
    instr(4'h3, 4'h0, 4'hF, 4'h1, 64'h7, 64'h0, 1'b0, 1'b0);
    instr(4'h3, 4'h0, 4'hF, 4'h2, 64'h5, 64'h0, 1'b0, 1'b0);
    instr(4'h6, 4'h0, 4'h1, 4'h2, 64'd12, 64'h0, 1'b0, 1'b0);
    chk("opq_valA", bus.valA, 64'h7);
    chk("opq_valB", bus.valB, 64'h5);
    peek("opq_r2", 4'h2, 64'd12);
    instr(4'h2, 4'h1, 4'h1, 4'h3, 64'h9, 64'h0, 1'b0, 1'b0);
    peek("cmov_nc_r3", 4'h3, 64'h0);
    instr(4'h2, 4'h1, 4'h1, 4'h3, 64'h9, 64'h0, 1'b1, 1'b0);
    peek("cmov_c_r3", 4'h3, 64'h9);
    instr(4'hB, 4'h0, 4'h4, 4'hF, 64'h208, 64'hABC, 1'b0, 1'b0);
    peek("popq_rsp", 4'h4, 64'hABC);
    instr(4'hA, 4'h0, 4'h1, 4'hF, 64'hAB4, 64'h0, 1'b0, 1'b0);
    chk("pushq_valA", bus.valA, 64'h7);
    chk("pushq_valB", bus.valB, 64'hABC);
    peek("pushq_rsp", 4'h4, 64'hAB4);
    instr(4'h1, 4'h5, 4'hF, 4'hF, 64'h0, 64'h0, 1'b0, 1'b1);
    chk("stray_dec_perr", 64'(proto_err), 64'h1);
    peek("stray_dec_r1", 4'h1, 64'h7);
    do_reset();
    bus.wb_req = 1; bus.valE = 64'h99; bus.icode = 4'h3; bus.rB = 4'h2;
    step();
    bus.wb_req = 0;
    exp_perr = 1;
    chk("idle_wb_perr", 64'(proto_err), 64'h1);
    chk("idle_wb_ack", 64'(bus.wb_ack), 64'h0);
    peek("idle_wb_r2", 4'h2, 64'h0);
    do_reset();
    chk("reset_perr", 64'(proto_err), 64'h0);
    instr(4'hC, 4'h0, 4'h1, 4'h2, 64'h77, 64'h88, 1'b1, 1'b0);
    chk("illegal_perr", 64'(proto_err), 64'h1);
    peek("illegal_r2", 4'h2, 64'h0);
    do_reset();
    instr(4'h0, 4'h0, 4'h1, 4'h2, 64'h33, 64'h44, 1'b1, 1'b0);
    chk("halt_flag", 64'(halted), 64'h1);
    peek("halt_r2", 4'h2, 64'h0);
    bus.dec_req = 1; bus.icode = 4'h6; bus.rA = 4'h4; bus.rB = 4'h4;
    step();
    bus.dec_req = 0;
    chk("halted_no_ack", 64'(bus.dec_ack), 64'h0);
    step();
    chk("halted_valA", bus.valA, 64'h0);
    do_reset();
    chk("reset_halted", 64'(halted), 64'h0);
    bus.dec_req = 1; bus.icode = 4'h3; bus.ifun = 4'h0; bus.rA = 4'hF; bus.rB = 4'h5;
    step();
    bus.dec_req = 0;
    exp_dec_ack = 1; exp_valA = 0; exp_valB = 0; exp_ifun = 0;
    step();
    exp_dec_ack = 0;
    bus.wb_req = 1; bus.valE = 64'hDEAD; rst = 1;
    step();
    rst = 0;
    bus.wb_req = 0;
    model_reset();
    peek("rst_mid_r5", 4'h5, 64'h0);
    peek("rst_mid_rsp", 4'h4, 64'h200);
    step();
    chk("rst_mid_no_ack", 64'(bus.wb_ack), 64'h0);
    instr(4'h3, 4'h0, 4'hF, 4'h5, 64'h31, 64'h0, 1'b0, 1'b0);
    peek("after_rst_r5", 4'h5, 64'h31);
    step();
    chk_on = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/decode_writeback.md
Name: decode_writeback

Overview:
- Y86-64 register-file block at both ends of the execute stage.
- Decode side: takes icode/ifun/rA/rB from fetch, reads the 15-entry register file and presents valA/valB to execute.
- Writeback side: takes valE/cnd from execute and valM from memory, then writes the destination registers, including cmovXX gating by cnd.
- A small FSM enforces strict decode -> writeback ordering per instruction, using strobe/acknowledge pulses in the codebase's flag style.

Parameters:
- DATA_W, 64, register and value width.
- NREG, 15, number of architectural registers (index 0xF = none).
- RSP_IDX, 4, index of %rsp.
- RSP_INIT, 64'h200, value loaded into %rsp on reset; all other registers reset to 0.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- dec_req  in  1  one-cycle strobe: fetch fields valid.
- icode  in  4  instruction code.
- ifun  in  4  function code (latched, passed through).
- rA  in  4  register specifier A.
- rB  in  4  register specifier B.
- valA  out  64  decoded operand A (registered).
- valB  out  64  decoded operand B (registered).
- dec_ack  out  1  one-cycle pulse: valA/valB valid (feeds execute's start flag).
- wb_req  in  1  one-cycle strobe: valE/valM/cnd valid.
- valE  in  64  execute result.
- valM  in  64  memory read data.
- cnd  in  1  condition result from execute.
- wb_ack  out  1  one-cycle pulse: writeback committed.
- halted  out  1  sticky, set by halt.
- proto_err  out  1  sticky protocol-violation flag.
- dbg_addr  in  4  debug read index.
- dbg_data  out  64  combinational read of reg[dbg_addr]; 0 when dbg_addr = 0xF.

Behaviour:
- Reset (synchronous):
  - reg[RSP_IDX] = RSP_INIT; all other registers = 0.
  - valA = valB = 0; dec_ack = wb_ack = halted = proto_err = 0.
  - State = IDLE.
  - Reset asserted mid-instruction aborts the instruction; no pending write occurs.
- FSM states: IDLE, DEC_ACK, WAIT_WB, WB_ACK.
- IDLE:
  - On dec_req and !halted: latch icode/ifun/rA/rB, register valA/valB -> DEC_ACK.
  - dec_req while halted: ignored.
  - wb_req in IDLE: ignored, proto_err = 1.
- DEC_ACK: dec_ack = 1 for exactly this cycle -> WAIT_WB.
- WAIT_WB:
  - On wb_req: perform writes at this edge -> WB_ACK.
  - dec_req in DEC_ACK/WAIT_WB/WB_ACK: ignored, proto_err = 1.
- WB_ACK: wb_ack = 1 for exactly this cycle -> IDLE.
- Latency: dec_req edge k -> dec_ack high in cycle k+1; wb_req edge m -> register visible on dbg_data and wb_ack high in cycle m+1.
- srcA selection:
  - icode 2, 4, 6, A: rA.
  - icode 9, B: RSP_IDX.
  - otherwise none.
- srcB selection:
  - icode 4, 5, 6: rB.
  - icode 8, 9, A, B: RSP_IDX.
  - otherwise none.
- Reading index 0xF or "none" yields 0.
- dstE selection (uses latched fields):
  - icode 2: rB if cnd, else none (cmovXX; ifun 0 always has cnd = 1 from execute).
  - icode 3, 6: rB.
  - icode 8, 9, A, B: RSP_IDX.
- dstM selection: icode 5, B: rA.
- Writes: dstE <= valE and dstM <= valM at the same edge. If dstE == dstM (popq %rsp), valM wins.
- Writes to index 0xF are dropped.
- icode 0 (halt): decode completes normally with valA = valB = 0; halted sets at the writeback edge; no register writes.
- icode 1 (nop) and 7 (jXX): no sources, no destinations; the handshake still runs.
- Illegal icode (> 0xB): treated as nop and sets proto_err.
- All arithmetic is 64-bit unsigned storage; no width conversion.

Decomposition:
- Shared package y86_pkg:
  - icode constants (HALT=0 … POPQ=B).
  - register index constants (RSP=4, RNONE=F).
  - FSM state enum.
  - DATA_W.
- One sub-module, y86_regfile:
  - 15x64 storage.
  - Two combinational read ports plus the debug port.
  - Two write ports, with port M taking priority on address match.
  - Synchronous reset.
- The FSM and src/dst selection logic live in decode_writeback.

Test Plan:
1. Reset, then read dbg_addr=4 and dbg_addr=0 -> 0x200 and 0.
2. irmovq: dec_req(icode=3, rB=2); wb_req(valE=0x55) -> dec_ack one cycle after, wb_ack next, reg2=0x55.
3. OPq: preload reg1=7, reg2=5; dec_req(icode=6, rA=1, rB=2) -> valA=7, valB=5 with dec_ack; wb_req(valE=12) -> reg2=12.
4. cmovXX gating: icode=2, rA=1, rB=3 with wb_req cnd=0, valE=9 -> reg3 unchanged. Repeat with cnd=1 -> reg3=9.
5. popq %rsp: icode=B, rA=4; wb_req(valE=0x208, valM=0xABC) -> reg4=0xABC; pushq (icode A) decode -> valB=0xABC.
6. Protocol and halt cases:
   - wb_req in IDLE -> proto_err=1, no writes.
   - halt then dec_req -> halted=1, no dec_ack.
   - rst mid-WAIT_WB -> reset values, state IDLE.
